// File: rtl/mdu_issue_ctrl_if.sv
// Bundle of the pipeline request/result signals and the MDU Start/Busy/MDUOp bus.
// The slave view belongs to the issue controller; the master view belongs to the environment.
interface mdu_issue_ctrl_if;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        mdu_start;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic        mdu_busy;
  logic [31:0] mdu_hi;
  logic [31:0] mdu_lo;
  logic        done;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        stall;
  logic [1:0]  err;

  modport master (
    output req_valid, req_op, req_a, req_b, mdu_busy, mdu_hi, mdu_lo,
    input  req_ready, mdu_start, mdu_op, mdu_a, mdu_b, done, res_hi, res_lo, stall, err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, mdu_busy, mdu_hi, mdu_lo,
    output req_ready, mdu_start, mdu_op, mdu_a, mdu_b, done, res_hi, res_lo, stall, err
  );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// E-stage initiator for the multiply/divide unit: accepts one HI/LO instruction at a time,
// runs the Start/Busy handshake, captures HI/LO and flags protocol errors.
module mdu_issue_ctrl #(
  parameter int TIMEOUT  = 16,
  parameter int RISE_WIN = 2
) (
  input  logic            clk,
  input  logic            reset,
  mdu_issue_ctrl_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_MULT = 4'd1;
  localparam logic [3:0] OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MTHI = 4'd5;
  localparam logic [3:0] OP_MFHI = 4'd7;
  localparam logic [3:0] OP_MFLO = 4'd8;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, XFER, DONE} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      op_reg;
  logic [31:0]     a_reg, b_reg;
  logic [CW-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic            seen_reg, seen_next;
  logic [31:0]     hi_reg, hi_next, lo_reg, lo_next;
  logic [1:0]      err_reg, err_next;
  logic            accept;
  logic            drive_bus;

  assign accept  = bus.req_valid && (state_reg == IDLE);
  assign cnt_inc = cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      cnt_reg   <= '0;
      seen_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      seen_reg  <= seen_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      err_reg   <= err_next;
      if (accept) begin
        op_reg <= bus.req_op;
        a_reg  <= bus.req_a;
        b_reg  <= bus.req_b;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    seen_next  = seen_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op >= OP_MULT && bus.req_op <= OP_DIVU) begin
            state_next = ISSUE;
          end else if (bus.req_op >= OP_MTHI && bus.req_op <= OP_MFLO) begin
            state_next = XFER;
          end else begin
            state_next  = DONE;
            err_next[1] = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_next = WAIT;
        cnt_next   = '0;
        seen_next  = 1'b0;
      end
      WAIT: begin
        cnt_next = cnt_inc;
        if (bus.mdu_busy) begin
          seen_next = 1'b1;
        end
        // A falling Busy after it was seen is completion; it wins over a same-cycle timeout.
        if (seen_reg && !bus.mdu_busy) begin
          hi_next    = bus.mdu_hi;
          lo_next    = bus.mdu_lo;
          state_next = DONE;
        end else if ((!seen_reg && !bus.mdu_busy && cnt_inc == CW'(RISE_WIN)) ||
                     (cnt_inc == CW'(TIMEOUT))) begin
          err_next[0] = 1'b1;
          state_next  = IDLE;
        end
      end
      XFER: begin
        if (op_reg == OP_MFHI) begin
          hi_next = bus.mdu_hi;
        end
        if (op_reg == OP_MFLO) begin
          lo_next = bus.mdu_lo;
        end
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The operand bus carries the captured request from Start until the op retires.
  assign drive_bus     = (state_reg == ISSUE) || (state_reg == WAIT) || (state_reg == XFER);
  assign bus.req_ready = (state_reg == IDLE);
  assign bus.stall     = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.mdu_start = (state_reg == ISSUE);
  assign bus.mdu_op    = drive_bus ? op_reg : 4'd0;
  assign bus.mdu_a     = drive_bus ? a_reg : 32'd0;
  assign bus.mdu_b     = drive_bus ? b_reg : 32'd0;
  assign bus.res_hi    = hi_reg;
  assign bus.res_lo    = lo_reg;
  assign bus.err       = err_reg;
endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Initiator side of the multiply/divide unit (MDU) Start/Busy/MDUOp interface; sits in the E stage between the pipeline and the MDU.
- Accepts one HI/LO instruction at a time from the pipeline on a valid/ready handshake and sequences the MDU's Start/Busy protocol.
- Captures the MDU's HI/LO outputs and reports completion with a one-cycle done pulse.
- Raises sticky error flags on protocol violations (Busy never rising, Busy stuck high, illegal op).

Parameters:
- TIMEOUT, 16, maximum WAIT-state cycles before a timeout error.
- RISE_WIN, 2, cycles after ISSUE within which mdu_busy must rise.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline has an HI/LO instruction.
- req_op  in  4  op code: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo.
- req_a  in  32  operand rs.
- req_b  in  32  operand rt.
- req_ready  out  1  high iff state==IDLE.
- mdu_start  out  1  one-cycle Start pulse to the MDU.
- mdu_op  out  4  MDUOp to the MDU; 0 when idle.
- mdu_a  out  32  A operand to the MDU.
- mdu_b  out  32  B operand to the MDU.
- mdu_busy  in  1  MDU Busy.
- mdu_hi  in  32  MDU HI.
- mdu_lo  in  32  MDU LO.
- done  out  1  one-cycle completion pulse.
- res_hi  out  32  captured HI.
- res_lo  out  32  captured LO.
- stall  out  1  high iff state!=IDLE; drives the D-stage freeze.
- err  out  2  sticky error flags: bit0 timeout, bit1 illegal op.

Behaviour:
- Reset values:
  - state=IDLE.
  - mdu_start=0, mdu_op=0, mdu_a=0, mdu_b=0.
  - done=0, res_hi=0, res_lo=0, err=0.
  - stall=0, req_ready=1.
- States: IDLE, ISSUE, WAIT, XFER, DONE.
- Accept: on a clock edge with req_valid && req_ready, register req_op, req_a and req_b.
- IDLE transitions after accept:
  - op 1-4 -> ISSUE.
  - op 5-8 -> XFER.
  - op 0 or op > 8 -> DONE; set err[1]; res_* unchanged.
- ISSUE (exactly 1 cycle):
  - mdu_start=1; mdu_op, mdu_a, mdu_b = registered values.
  - Always -> WAIT; clear cycle counter and seen_busy.
- WAIT:
  - mdu_start=0. mdu_op, mdu_a, mdu_b are held stable.
  - Counter increments every cycle.
  - When mdu_busy=1: set seen_busy.
  - When seen_busy=1 and mdu_busy=0: capture mdu_hi/mdu_lo into res_hi/res_lo on that edge -> DONE.
  - Error exits, both -> IDLE with no done pulse and res_* unchanged:
    - seen_busy=0 and counter reaches RISE_WIN: set err[0].
    - counter reaches TIMEOUT: set err[0].
- XFER (exactly 1 cycle, mdu_start=0, mdu_op=op):
  - mthi/mtlo: mdu_a=req_a. The MDU writes HI/LO on this edge.
  - mfhi/mflo: capture mdu_hi/mdu_lo into res_hi/res_lo on this edge.
  - Always -> DONE.
- DONE (1 cycle): done=1; mdu_op=0 -> IDLE.
- Latency:
  - With an accept edge at the end of cycle 0 and an MDU Busy window of N cycles starting in cycle 2, done is high in cycle N+3. That is cycle 8 for mult (N=5) and cycle 13 for div (N=10).
  - XFER ops: done in cycle 2.
- No new request is accepted until the cycle after DONE; back-to-back throughput is one op per (latency+1) cycles.
- req_a, req_b and req_op changes while req_ready=0 are ignored.
- Reset in any state, including mid-WAIT: return to IDLE on that edge with all outputs at reset values and err cleared. The MDU resets from the same reset.
- err bits are sticky until reset. They do not block further requests.
- mdu_busy high while in IDLE (e.g. a stray Busy) is ignored and does not affect stall.

Test Plan:
- mult, a=3, b=5, MDU model with 5-cycle Busy -> mdu_start high exactly 1 cycle; done in cycle 8; res_lo=15, res_hi=0; stall high cycles 1-8.
- div, a=13456, b=134, 10-cycle Busy -> done in cycle 13; res_lo=100, res_hi=56; req_ready=0 throughout.
- multu, a=0xFFFFFFFF, b=2 -> res_hi=0x00000001, res_lo=0xFFFFFFFE; then mthi a=0x1234 followed by mfhi -> each done 2 cycles after accept; res_hi=0x00001234.
- MDU stub with mdu_busy tied 0, mult request -> err[0]=1 three cycles after ISSUE; no done pulse; returns to IDLE; next mflo request completes normally.
- div with reset asserted in the 4th WAIT cycle -> next cycle state=IDLE, stall=0, done=0, res_*=0, err=0.
- req_op=0xF -> done in cycle 1, err[1]=1, res_* unchanged, mdu_start never asserted.
